// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle for fifo_sync_param.
// master: the producer/consumer side; slave: the FIFO itself.
interface fifo_sync_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] data_in;
    logic              enable_wrt;
    logic              enable_rd;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output data_in, enable_wrt, enable_rd,
        input  data_out, valid_out, count, full, empty,
        input  almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  data_in, enable_wrt, enable_rd,
        output data_out, valid_out, count, full, empty,
        output almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy, threshold flags and error pulses.
// Define FIFO_FWFT_EN for first-word fall-through; otherwise reads are registered.
module fifo_sync_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AF_TH  = 6,
    parameter int unsigned AE_TH  = 2
) (
    input logic              clk,
    input logic              rst,
    fifo_sync_param_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);
    localparam logic [CW-1:0] CntAf   = CW'(AF_TH);
    localparam logic [CW-1:0] CntAe   = CW'(AE_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, underflow_q;
    logic              full, empty, rd_acc, wr_acc;

    assign full   = (count_q == CntFull);
    assign empty  = (count_q == '0);
    assign rd_acc = bus.enable_rd & ~empty;
    // A write at full still goes in when the same edge pops a word.
    assign wr_acc = bus.enable_wrt & (~full | rd_acc);

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q     <= count_d;
            overflow_q  <= bus.enable_wrt & full & ~rd_acc;
            underflow_q <= bus.enable_rd & empty;
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.data_out  = mem_q[rd_ptr_q];
    assign bus.valid_out = ~empty;
`else
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_acc;
            if (rd_acc) data_q <= mem_q[rd_ptr_q];
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CntAf);
    assign bus.almost_empty = (count_q <= CntAe);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
